// File: rtl/alu_issue_scoreboard.sv
// rtl/alu_issue_scoreboard.sv - decode-to-ALU issue control with RAW/WAW scoreboarding and drain handshake
// Per-register pending counters gate issue; a small FSM quiesces the pipe on drain_req.
module alu_issue_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs1_addr,
  input  logic              dec_rs1_used,
  input  logic [ADDR_W-1:0] dec_rs2_addr,
  input  logic              dec_rs2_used,
  input  logic [ADDR_W-1:0] dec_rd_addr,
  input  logic              dec_rd_wr_en,
  output logic              ex_issue,
  input  logic              wb_retire,
  input  logic [ADDR_W-1:0] wb_rd_addr,
  input  logic              wb_rd_wr_en,
  input  logic              drain_req,
  output logic              drain_ack,
  output logic [2:0]        inflight,
  output logic              err_underflow
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DRAINED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] pend [NUM_REGS];
  logic [2:0]       inflight_next;
  logic             hazard, fire;
  logic             inc_en, dec_en, same_reg;
  logic             pend_uflow, infl_uflow;

  always_comb begin
    hazard = (dec_rs1_used && dec_rs1_addr != '0 && pend[dec_rs1_addr] != '0) ||
             (dec_rs2_used && dec_rs2_addr != '0 && pend[dec_rs2_addr] != '0) ||
             (dec_rd_wr_en && dec_rd_addr != '0 && pend[dec_rd_addr] == CNT_MAX);
    dec_ready = (state == S_RUN) && !drain_req && (inflight < 3'(MAX_INFLIGHT)) && !hazard;
    fire = dec_valid && dec_ready;
  end

  // An increment and a decrement of the same register cancel; register 0 is never tracked.
  always_comb begin
    inc_en     = fire && dec_rd_wr_en && dec_rd_addr != '0;
    dec_en     = wb_retire && wb_rd_wr_en && wb_rd_addr != '0;
    same_reg   = inc_en && dec_en && (dec_rd_addr == wb_rd_addr);
    pend_uflow = dec_en && !same_reg && pend[wb_rd_addr] == '0;
    infl_uflow = wb_retire && inflight == '0;
  end

  always_comb begin
    inflight_next = inflight;
    if (fire && !wb_retire) begin
      inflight_next = inflight + 3'd1;
    end else if (wb_retire && !fire && inflight != '0) begin
      inflight_next = inflight - 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (!fire && drain_req) begin
          state_next = (inflight == '0) ? S_DRAINED : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_next == '0) begin
          state_next = S_DRAINED;
        end
      end
      S_DRAINED: begin
        if (!drain_req) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_RUN;
      inflight      <= '0;
      ex_issue      <= 1'b0;
      drain_ack     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_next;
      inflight      <= inflight_next;
      ex_issue      <= fire;
      drain_ack     <= (state_next == S_DRAINED);
      err_underflow <= err_underflow | pend_uflow | infl_uflow;
    end
  end

  // A decrement of an already-zero counter holds it at zero rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
    end else if (!same_reg) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_en && dec_rd_addr == ADDR_W'(r)) begin
          pend[r] <= pend[r] + CNT_W'(1);
        end else if (dec_en && wb_rd_addr == ADDR_W'(r) && pend[r] != '0) begin
          pend[r] <= pend[r] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scoreboard.sv
// tb/tb_alu_issue_scoreboard.sv - scoreboard bench for alu_issue_scoreboard
// Driver steps a behavioural model and queues expectations; a negedge monitor compares.
module tb_alu_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_ready;
  logic [4:0] dec_rs1_addr = '0;
  logic       dec_rs1_used = 1'b0;
  logic [4:0] dec_rs2_addr = '0;
  logic       dec_rs2_used = 1'b0;
  logic [4:0] dec_rd_addr = '0;
  logic       dec_rd_wr_en = 1'b0;
  logic       ex_issue;
  logic       wb_retire = 1'b0;
  logic [4:0] wb_rd_addr = '0;
  logic       wb_rd_wr_en = 1'b0;
  logic       drain_req = 1'b0;
  logic       drain_ack;
  logic [2:0] inflight;
  logic       err_underflow;

  alu_issue_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .MAX_INFLIGHT(3), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
    .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
    .dec_rd_addr(dec_rd_addr), .dec_rd_wr_en(dec_rd_wr_en),
    .ex_issue(ex_issue),
    .wb_retire(wb_retire), .wb_rd_addr(wb_rd_addr), .wb_rd_wr_en(wb_rd_wr_en),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .inflight(inflight), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit rdy;
    int infl;
    bit ack;
    bit err;
  } rec_t;

  typedef struct {
    int rd;
    bit w;
  } ent_t;

  rec_t cyc_q[$];
  int   issue_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   last_fire;

  // Reference model: pending-write count per register, in-flight count, sticky error, drain mode.
  int m_pend[32];
  int m_infl;
  bit m_err;
  int m_mode;  // 0 run, 1 draining, 2 drained

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_infl = 0;
    m_err  = 1'b0;
    m_mode = 0;
  endtask

  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit w, input bit ret, input int wba, input bit wbw,
                      input bit dq);
    rec_t r;
    bit   hz, rdy, fire, inc, dcr;
    int   ni;
    dec_valid = v; dec_rs1_addr = 5'(rs1); dec_rs1_used = u1;
    dec_rs2_addr = 5'(rs2); dec_rs2_used = u2;
    dec_rd_addr = 5'(rd); dec_rd_wr_en = w;
    wb_retire = ret; wb_rd_addr = 5'(wba); wb_rd_wr_en = wbw;
    drain_req = dq;
    hz = (u1 && rs1 != 0 && m_pend[rs1] > 0) || (u2 && rs2 != 0 && m_pend[rs2] > 0) ||
         (w && rd != 0 && m_pend[rd] == 3);
    rdy  = (m_mode == 0) && !dq && (m_infl < 3) && !hz;
    fire = v && rdy;
    last_fire = fire;
    r.cyc = cyc; r.rdy = rdy; r.infl = m_infl; r.ack = (m_mode == 2); r.err = m_err;
    cyc_q.push_back(r);
    if (fire) issue_q.push_back(cyc + 1);
    inc = fire && w && rd != 0;
    dcr = ret && wbw && wba != 0;
    if (!(inc && dcr && rd == wba)) begin
      if (dcr) begin
        if (m_pend[wba] == 0) m_err = 1'b1;
        else m_pend[wba]--;
      end
      if (inc) m_pend[rd]++;
    end
    ni = m_infl;
    if (ret && m_infl == 0) m_err = 1'b1;
    if (fire && !ret) ni++;
    else if (ret && !fire && m_infl > 0) ni--;
    case (m_mode)
      0: if (!fire && dq) m_mode = (m_infl == 0) ? 2 : 1;
      1: if (ni == 0) m_mode = 2;
      default: if (!dq) m_mode = 0;
    endcase
    m_infl = ni;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit dq);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dq);
  endtask

  task automatic retire(input int wba, input bit dq);
    step(0, 0, 0, 0, 0, 0, 0, 1, wba, 1, dq);
  endtask

  task automatic issue(input int rd);
    step(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    rec_t r;
    int   t;
    if (cyc_q.size() > 0) begin
      r = cyc_q.pop_front();
      chk("dec_ready", int'(dec_ready), int'(r.rdy));
      chk("inflight", int'(inflight), r.infl);
      chk("drain_ack", int'(drain_ack), int'(r.ack));
      chk("err_underflow", int'(err_underflow), int'(r.err));
      if (ex_issue) begin
        if (issue_q.size() == 0) begin
          chk("ex_issue_spurious", 1, 0);
        end else begin
          t = issue_q.pop_front();
          chk("ex_issue_cycle", r.cyc, t);
        end
      end else if (issue_q.size() > 0 && issue_q[0] <= r.cyc) begin
        t = issue_q.pop_front();
        chk("ex_issue_missing", 0, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ent_t fl[$];
    ent_t e;
    bit   dq;
    model_reset();
    #12;
    chk("reset_inflight", int'(inflight), 0);
    chk("reset_ex_issue", int'(ex_issue), 0);
    chk("reset_drain_ack", int'(drain_ack), 0);
    chk("reset_err", int'(err_underflow), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back independent issues
    step(1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 0);
    step(1, 3, 1, 4, 1, 2, 1, 0, 0, 0, 0);
    idle(0);
    retire(1, 0);
    retire(2, 0);

    // RAW stall until the producer retires
    issue(5);
    repeat (3) step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 1, 5, 1, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    retire(6, 0);

    // window full
    issue(1); issue(2); issue(3);
    repeat (2) step(1, 9, 1, 10, 1, 8, 1, 0, 0, 0, 0);
    step(1, 9, 1, 10, 1, 8, 1, 1, 1, 1, 0);
    step(1, 9, 1, 10, 1, 8, 1, 0, 0, 0, 0);
    retire(2, 0); retire(3, 0); retire(8, 0);

    // simultaneous fire and retire of the same rd, then x0 writes
    issue(7);
    step(1, 0, 0, 0, 0, 7, 1, 1, 7, 1, 0);
    idle(0);
    retire(7, 0);
    issue(0);
    step(1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0);
    retire(0, 0);
    retire(11, 0);

    // drain with work in flight
    issue(1); issue(2);
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
    retire(1, 1);
    retire(2, 1);
    idle(1); idle(1);
    idle(0); idle(0);

    // randomized traffic; retirements follow issue order
    dq = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit ret;
      int rd;
      bit w;
      if ($urandom_range(0, 24) == 0) dq = !dq;
      ret = (fl.size() > 0) && ($urandom_range(0, 9) < 4);
      e.rd = 0; e.w = 1'b0;
      if (ret) e = fl.pop_front();
      rd = $urandom_range(0, 7);
      w  = ($urandom_range(0, 9) < 8);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), rd, w, ret, e.rd, e.w, dq);
      if (last_fire) begin
        e.rd = rd; e.w = w;
        fl.push_back(e);
      end
    end
    while (fl.size() > 0) begin
      e = fl.pop_front();
      step(0, 0, 0, 0, 0, 0, 0, 1, e.rd, e.w, 0);
    end
    idle(0); idle(0);

    // underflow: counter decrement at zero, then retire with nothing in flight
    issue(4);
    retire(9, 0);
    retire(4, 0);
    idle(0);

    // asynchronous reset in the middle of a drain
    issue(1); issue(2);
    idle(1); idle(1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_inflight", int'(inflight), 0);
    chk("async_rst_drain_ack", int'(drain_ack), 0);
    chk("async_rst_ex_issue", int'(ex_issue), 0);
    chk("async_rst_err", int'(err_underflow), 0);
    chk("async_rst_dec_ready", int'(dec_ready), 0);
    issue_q.delete();
    @(posedge clk);
    #3;
    chk("held_rst_inflight", int'(inflight), 0);
    drain_req = 1'b0;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    issue(5);
    idle(0);
    retire(5, 0);
    idle(0); idle(0);

    chk("issue_q_empty", issue_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
